// File: rtl/fpcvt_pkg.sv
// Shared types, constants and the rounding function for the 8-bit float packer.
// Byte layout is {sign, exp[2:0], sig[3:0]}.
package fpcvt_pkg;

  localparam int EXP_W  = 3;
  localparam int SIG_W  = 4;
  localparam int BYTE_W = 1 + EXP_W + SIG_W;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp8_t;

  localparam logic [EXP_W+SIG_W-1:0] FP_MAX_MAG = {3'd7, 4'hF};

  typedef struct packed {
    fp8_t fp;
    logic sat;
    logic up;
  } fp_round_t;

  // Round-half-up on the single truncated bit. A carry out of the significand
  // renormalises to 1000 with exp+1; a carry out of the top exponent saturates.
  function automatic fp_round_t fp_round(
    input logic             sign,
    input logic [EXP_W-1:0] exp,
    input logic [SIG_W-1:0] sig,
    input logic             rnd
  );
    fp_round_t r;
    r.fp.sign = sign;
    r.fp.exp  = exp;
    r.fp.sig  = sig;
    r.sat     = 1'b0;
    r.up      = 1'b0;
    if (rnd) begin
      if (sig != '1) begin
        r.fp.sig = sig + 4'd1;
        r.up     = 1'b1;
      end else if (exp != '1) begin
        r.fp.exp = exp + 3'd1;
        r.fp.sig = {1'b1, {(SIG_W-1){1'b0}}};
        r.up     = 1'b1;
      end else begin
        {r.fp.exp, r.fp.sig} = FP_MAX_MAG;
        r.sat                = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fpcvt_round_pack_if.sv
// Input sample and output byte handshakes of the round/pack stage.
// Both sides: a transfer happens on a rising clk edge where valid && ready.
interface fpcvt_round_pack_if;
  import fpcvt_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [SIG_W-1:0]  in_sig;
  logic              in_rnd;
  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_data;

  modport master (
    output in_valid, in_sign, in_exp, in_sig, in_rnd, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, in_rnd, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/fpcvt_fifo.sv
// Synchronous FIFO with registered full/empty flags and a registered-array
// head read; the count carries one extra bit so full and empty are distinct.
module fpcvt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_cnt_nxt;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_count - 1'b1;
    end
  end

  // Full is held high through reset so nothing is written while flushing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b1;
      r_empty  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == FULL_CNT);
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/fpcvt_round_pack.sv
// Rounds the converter output, packs it into a float byte and queues it in a
// small FIFO. Saturation and round-up events are counted with sticky limits.
module fpcvt_round_pack
  import fpcvt_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  fpcvt_round_pack_if.slave bus,
  output logic [CNT_W-1:0] sat_count,
  output logic [CNT_W-1:0] rnd_count
);

  fp_round_t   w_rnd;
  logic        w_accept;
  logic        w_full;
  logic        w_empty;
  logic [BYTE_W-1:0] w_head;
  logic [CNT_W-1:0]  r_sat_count;
  logic [CNT_W-1:0]  r_rnd_count;

  assign w_rnd    = fp_round(bus.in_sign, bus.in_exp, bus.in_sig, bus.in_rnd);
  assign w_accept = bus.in_valid && !w_full;

  fpcvt_fifo #(
    .W     (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.in_valid),
    .i_data  (w_rnd.fp),
    .i_pop   (bus.out_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_count <= '0;
      r_rnd_count <= '0;
    end else if (w_accept) begin
      if (w_rnd.sat && (r_sat_count != '1)) begin
        r_sat_count <= r_sat_count + 1'b1;
      end
      if (w_rnd.up && (r_rnd_count != '1)) begin
        r_rnd_count <= r_rnd_count + 1'b1;
      end
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_head;
  assign sat_count     = r_sat_count;
  assign rnd_count     = r_rnd_count;

endmodule

// File: tb/tb_fpcvt_round_pack.sv
// Randomised and directed bench for fpcvt_round_pack; expected bytes come from
// an arithmetic rounding model and are checked by a decoupled output monitor.
module tb_fpcvt_round_pack;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] sat_count;
  logic [CNT_W-1:0] rnd_count;

  fpcvt_round_pack_if bus();

  fpcvt_round_pack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sat_count (sat_count),
    .rnd_count (rnd_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int model_sat = 0;
  int model_rnd = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: treat sig+rnd as an integer; 16 renormalises to 8 with a higher
  // exponent, and an exponent past 7 clamps to the largest magnitude.
  function automatic void ref_round(input bit s, input int e, input int g, input bit r,
                                    output logic [7:0] b, output bit sat, output bit up);
    int m;
    int ee;
    m   = g + int'(r);
    ee  = e;
    sat = 1'b0;
    up  = r;
    if (m > 15) begin
      m  = m / 2;
      ee = ee + 1;
    end
    if (ee > 7) begin
      ee  = 7;
      m   = 15;
      sat = 1'b1;
      up  = 1'b0;
    end
    b = 8'(int'(s) * 128 + ee * 16 + m);
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input bit s, input int e, input int g, input bit r,
                      input int exp_byte, output int waits);
    logic [7:0] b;
    bit sat;
    bit up;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = 3'(e);
    bus.in_sig   = 4'(g);
    bus.in_rnd   = r;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        ref_round(s, e, g, r, b, sat, up);
        exp_q.push_back((exp_byte < 0) ? b : 8'(exp_byte));
        if (sat) model_sat = (model_sat < 255) ? model_sat + 1 : 255;
        if (up)  model_rnd = (model_rnd < 255) ? model_rnd + 1 : 255;
        @(posedge clk);
        #1;
        break;
      end
      waits++;
      @(posedge clk);
      #1;
      if (waits > 100) begin
        check("accept_timeout", waits, 0);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Output monitor: a pop happens on the next edge whenever this sees valid && ready.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", int'(bus.out_data), -1);
      end else begin
        check("out_data", int'(bus.out_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int total_w;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_sig    = '0;
    bus.in_rnd    = 1'b0;
    bus.out_ready = 1'b0;

    // Reset behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_sat", int'(sat_count), 0);
    check("rst_rnd", int'(rnd_count), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Directed rounding cases with one-cycle latency
    bus.out_ready = 1'b1;
    send(1'b0, 5, 4'hD, 1'b0, 8'h5D, w);
    @(negedge clk);
    check("latency_valid", int'(bus.out_valid), 1);
    check("latency_data", int'(bus.out_data), 8'h5D);
    check("cnt_rnd_0", int'(rnd_count), 0);
    check("cnt_sat_0", int'(sat_count), 0);
    @(posedge clk);
    #1;
    send(1'b0, 3, 4'hB, 1'b1, 8'h3C, w);
    send(1'b0, 2, 4'hF, 1'b1, 8'h38, w);
    @(negedge clk);
    check("cnt_rnd_2", int'(rnd_count), 2);
    @(posedge clk);
    #1;
    send(1'b0, 7, 4'hF, 1'b1, 8'h7F, w);
    @(negedge clk);
    check("cnt_sat_1", int'(sat_count), 1);
    check("cnt_rnd_still_2", int'(rnd_count), 2);
    @(posedge clk);
    #1;
    send(1'b1, 0, 4'h5, 1'b1, 8'h86, w);
    send(1'b0, 0, 4'h7, 1'b1, 8'h08, w);
    drain();

    // Backpressure: two fill the FIFO, the third waits until out_ready rises
    bus.out_ready = 1'b0;
    send(1'b0, 1, 1, 1'b0, -1, w);
    send(1'b0, 2, 2, 1'b0, -1, w);
    fork
      send(1'b0, 3, 3, 1'b0, -1, w);
      begin
        @(negedge clk);
        check("bp_in_ready", int'(bus.in_ready), 0);
        check("bp_head", int'(bus.out_data), 8'h11);
        repeat (3) @(negedge clk);
        check("bp_hold_valid", int'(bus.out_valid), 1);
        check("bp_hold_data", int'(bus.out_data), 8'h11);
        check("bp_in_ready_held", int'(bus.in_ready), 0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    check("bp_third_waited", (w > 0) ? 1 : 0, 1);
    drain();

    // Streaming random samples: with out_ready high nothing should stall
    total_w = 0;
    for (int i = 0; i < 20; i++) begin
      send(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15),
           1'($urandom_range(0, 1)), -1, w);
      total_w += w;
    end
    check("stream_no_stall", total_w, 0);
    drain();
    @(negedge clk);
    check("stream_rnd", int'(rnd_count), model_rnd);
    check("stream_sat", int'(sat_count), model_sat);
    @(posedge clk);
    #1;

    // Counter saturation through 300 round-ups
    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 14), 1'b1, -1, w);
    end
    drain();
    @(negedge clk);
    check("rnd_sticks", int'(rnd_count), 255);
    check("sat_after_sticky", int'(sat_count), model_sat);
    @(posedge clk);
    #1;

    // Reset with two entries buffered and a sample presented
    bus.out_ready = 1'b0;
    send(1'b0, 4, 9, 1'b1, -1, w);
    send(1'b1, 6, 3, 1'b0, -1, w);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_exp   = 3'd1;
    bus.in_sig   = 4'd2;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_rst_in_ready", int'(bus.in_ready), 0);
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    model_sat = 0;
    model_rnd = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("after_rst_out_valid", int'(bus.out_valid), 0);
    check("after_rst_out_data", int'(bus.out_data), 0);
    check("after_rst_in_ready", int'(bus.in_ready), 1);
    check("after_rst_sat", int'(sat_count), 0);
    check("after_rst_rnd", int'(rnd_count), 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      send(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15),
           1'($urandom_range(0, 1)), -1, w);
    end
    drain();
    @(negedge clk);
    check("final_rnd", int'(rnd_count), model_rnd);
    check("final_sat", int'(sat_count), model_sat);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
